cv32e40p_obi_data_responder: RTL and testbench

// Single-port data memory that answers the core's LSU data-side OBI-style requests.
// It is the responder end of the req/gnt/rvalid handshake that the load/store path initiates.
// The load data it returns feeds the EX/WB path.

---
 rtl/cv32e40p_obi_data_responder.sv | 158 +++++++++++++++
 tb/tb_cv32e40p_obi_data_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_data_responder.sv
// cv32e40p_obi_data_responder
// Single-port data memory answering the LSU data-side req/gnt/rvalid handshake.
// Grant and response delays are programmable and one transaction is served at a time.
// Optional feature macro: CV32E40P_DMEM_ERR_EN (out-of-range accesses answer with err = 1).
// ADDR_WIDTH must be below 32 so that an upper address field exists.
module cv32e40p_obi_data_responder #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned GNT_LATENCY    = 0,
  parameter int unsigned RVALID_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned MAX_L = (GNT_LATENCY > RVALID_LATENCY) ? GNT_LATENCY : RVALID_LATENCY;
  // Counters are loaded with latency-1, so $clog2(MAX_L) bits are enough.
  localparam int unsigned CNT_W = (MAX_L < 2) ? 1 : $clog2(MAX_L);

  typedef enum logic [1:0] {
    IDLE,
    GNT_WAIT,
    RESP_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]   word_idx;
  logic               addr_oor;
  logic               gnt;
  logic               rvalid;
  logic               accept;
  logic               unused_bits;

  assign word_idx = data_addr_i[ADDR_WIDTH-1:2];

`ifdef CV32E40P_DMEM_ERR_EN
  assign addr_oor    = |data_addr_i[31:ADDR_WIDTH];
  assign unused_bits = ^data_addr_i[1:0];
`else
  assign addr_oor    = 1'b0;
  assign unused_bits = ^{data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0], err_q};
`endif

  // Next-state, counters, handshake strobes and capture of the granted request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = 1'b1;
      end
      GNT_WAIT: begin
        if (!data_req_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gnt     = 1'b1;
          state_d = RESP_WAIT;
          cnt_d   = CNT_W'(RVALID_LATENCY - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP_WAIT: begin
        if (cnt_q == '0) begin
          rvalid  = 1'b1;
          state_d = IDLE;
          // The response cycle also accepts a new request, allowing back-to-back.
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept && data_req_i) begin
      if (GNT_LATENCY == 0) begin
        gnt     = 1'b1;
        state_d = RESP_WAIT;
        cnt_d   = CNT_W'(RVALID_LATENCY - 1);
      end else begin
        state_d = GNT_WAIT;
        cnt_d   = CNT_W'(GNT_LATENCY - 1);
      end
    end

    if (rst) begin
      gnt    = 1'b0;
      rvalid = 1'b0;
    end

    if (gnt) begin
      err_d   = addr_oor;
      rdata_d = (data_we_i || addr_oor) ? '0 : mem_q[word_idx];
    end
  end

  // State, counter and captured response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commit on the grant edge; only enabled bytes are written, array not reset.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && !addr_oor) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = rvalid ? rdata_q : '0;
`ifdef CV32E40P_DMEM_ERR_EN
  assign data_err_o    = rvalid & err_q;
`else
  assign data_err_o    = 1'b0;
`endif
  assign busy_o        = (state_q == RESP_WAIT) && (cnt_q != '0) && !rst;

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Testbench for cv32e40p_obi_data_responder: two instances (default latencies and
// GNT_LATENCY=2 / RVALID_LATENCY=3) checked against a transaction-level memory model.
module tb_cv32e40p_obi_data_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        gnt   [2];
  logic [31:0] addr  [2];
  logic        we_i  [2];
  logic [3:0]  be_i  [2];
  logic [31:0] wdata [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  int unsigned gl [2];
  int unsigned rl [2];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mm [int unsigned];

  always #5 clk = ~clk;

  cv32e40p_obi_data_responder #(.ADDR_WIDTH(16), .GNT_LATENCY(0), .RVALID_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_addr_i(addr[0]),
    .data_we_i(we_i[0]), .data_be_i(be_i[0]), .data_wdata_i(wdata[0]), .data_rvalid_o(rvalid[0]),
    .data_rdata_o(rdata[0]), .data_err_o(err[0]), .busy_o(busy[0]));

  cv32e40p_obi_data_responder #(.ADDR_WIDTH(16), .GNT_LATENCY(2), .RVALID_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_addr_i(addr[1]),
    .data_we_i(we_i[1]), .data_be_i(be_i[1]), .data_wdata_i(wdata[1]), .data_rvalid_o(rvalid[1]),
    .data_rdata_o(rdata[1]), .data_err_o(err[1]), .busy_o(busy[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned mkey(input int d, input logic [31:0] a);
    return int'(d) * 65536 + int'(a[15:2]);
  endfunction

  function automatic logic model_oor(input logic [31:0] a);
`ifdef CV32E40P_DMEM_ERR_EN
    return |a[31:16];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
    int unsigned k = mkey(d, a);
    return mm.exists(k) ? mm[k] : 32'h0;
  endfunction

  task automatic model_wr(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w = model_rd(d, a);
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    mm[mkey(d, a)] = w;
  endtask

  // One complete transaction: checks grant latency, busy, response latency and payload.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
    int c, r;
    logic done;
    logic [31:0] exp_rd;
    logic exp_err;
    @(posedge clk); #1;
    req[d] = 1'b1; we_i[d] = w; addr[d] = a; be_i[d] = be; wdata[d] = wd;
    c = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (gnt[d]) done = 1'b1;
      else begin
        c++;
        if (c > 20) begin
          check("gnt_timeout", 32'd1, 32'd0);
          req[d] = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    check("gnt_latency", c, gl[d]);
    exp_err = model_oor(a);
    exp_rd  = (w || exp_err) ? 32'h0 : model_rd(d, a);
    if (w && !exp_err) model_wr(d, a, be, wd);
    @(posedge clk); #1;
    req[d] = 1'b0;
    r = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      r++;
      if (rvalid[d]) done = 1'b1;
      else begin
        check("busy_wait", {31'd0, busy[d]}, 32'd1);
        if (r > 20) begin
          check("rvalid_timeout", 32'd1, 32'd0);
          return;
        end
        @(posedge clk); #1;
      end
    end
    check("rvalid_latency", r, rl[d]);
    check("rdata", rdata[d], exp_rd);
    check("err", {31'd0, err[d]}, {31'd0, exp_err});
    check("busy_resp", {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    gl[0] = 0; rl[0] = 1; gl[1] = 2; rl[1] = 3;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; addr[d] = '0; we_i[d] = 1'b0; be_i[d] = '0; wdata[d] = '0;
    end

    // Reset held 3 cycles with req high: everything quiet.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_gnt", {31'd0, gnt[d]}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid[d]}, 32'd0);
        check("rst_busy", {31'd0, busy[d]}, 32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0; req[1] = 1'b0;

    // Full-word initialisation of the words used below.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, 32'(i * 4), 4'hF, $urandom);

    // Store/load and byte enables.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
      txn(d, 1'b0, 32'h100, 4'h0, 32'h0);
      txn(d, 1'b1, 32'h100, 4'b0101, 32'h11223344);
      txn(d, 1'b0, 32'h100, 4'h0, 32'h0);
      check("be_merge_model", model_rd(d, 32'h100), 32'hDE22BE44);
      txn(d, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF);
      txn(d, 1'b0, 32'h100, 4'h0, 32'h0);
    end

    // Back-to-back loads on the zero-wait instance.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      req[0] = 1'b1; we_i[0] = 1'b0; addr[0] = 32'(k * 4);
      @(negedge clk);
      check("b2b_gnt", {31'd0, gnt[0]}, 32'd1);
      check("b2b_rvalid", {31'd0, rvalid[0]}, (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("b2b_rdata", rdata[0], model_rd(0, 32'((k - 1) * 4)));
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    @(negedge clk);
    check("b2b_last_rvalid", {31'd0, rvalid[0]}, 32'd1);
    check("b2b_last_rdata", rdata[0], model_rd(0, 32'hC));
    check("b2b_last_gnt", {31'd0, gnt[0]}, 32'd0);

    // Request withdrawn before grant: no grant, no response.
    @(posedge clk); #1;
    req[1] = 1'b1; we_i[1] = 1'b1; addr[1] = 32'h8; be_i[1] = 4'hF; wdata[1] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_gnt", {31'd0, gnt[1]}, 32'd0);
      check("abort_rvalid", {31'd0, rvalid[1]}, 32'd0);
    end
    txn(1, 1'b0, 32'h8, 4'h0, 32'h0);

    // Reset after a store grant: response dropped, store stays committed.
    @(posedge clk); #1;
    req[1] = 1'b1; we_i[1] = 1'b1; addr[1] = 32'h20; be_i[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstmid_gnt", {31'd0, gnt[1]}, 32'd1);
    model_wr(1, 32'h20, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;
    req[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rstmid_rvalid", {31'd0, rvalid[1]}, 32'd0);
    end
    txn(1, 1'b0, 32'h20, 4'h0, 32'h0);

    // Upper-address access: error response or alias depending on build.
    txn(0, 1'b1, 32'h0001_0000, 4'hF, 32'h55AA55AA);
    txn(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0);

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      int d;
      logic [31:0] a;
      d = int'($urandom_range(1, 0));
      a = {(($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'h0), 10'h0, 4'($urandom), 2'($urandom)};
      txn(d, 1'($urandom), a, 4'($urandom), $urandom);
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
